// File: rtl/axi_rmw_pkg.sv
// axi_rmw_pkg: shared FSM states, AXI encodings and the SIZE helper for the RMW master
package axi_rmw_pkg;
  typedef enum logic [2:0] {S_IDLE, S_AR, S_R, S_AW, S_W, S_B, S_FIN} state_t;
  localparam logic [1:0] RESP_OKAY = 2'b00;
  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [3:0] CACHE_DEFAULT = 4'b0011;
  function automatic logic [2:0] axi_size(input int dw);
    return 3'($clog2(dw / 8));
  endfunction
endpackage

// File: rtl/rmw_beat_buffer.sv
// rmw_beat_buffer: DEPTH x DATA_W simple dual-port RAM; sync write port (we/waddr/wdata), registered read port (raddr -> rdata next cycle)
module rmw_beat_buffer
  import axi_rmw_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int DEPTH = 32,
  localparam int BA_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [BA_W-1:0]   waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [BA_W-1:0]   raddr,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [DEPTH];
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end
endmodule

// File: rtl/axi_burst_rmw_master.sv
// axi_burst_rmw_master: reads len beats from rd_base_addr, adds add_value per beat, writes them as one burst to wr_base_addr
// Ports: command (start/len/rd_base_addr/wr_base_addr/add_value), status (busy/done/error), full AXI4 master AR/R/AW/W/B channels.
module axi_burst_rmw_master
  import axi_rmw_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 32,
  parameter int MAX_BURST = 32,
  localparam int LEN_W = $clog2(MAX_BURST) + 1,
  localparam int BA_W = $clog2(MAX_BURST)
) (
  input  logic                ACLK,
  input  logic                ARESETn,
  input  logic                start,
  input  logic [LEN_W-1:0]    len,
  input  logic [ADDR_W-1:0]   rd_base_addr,
  input  logic [ADDR_W-1:0]   wr_base_addr,
  input  logic [DATA_W-1:0]   add_value,
  output logic                busy,
  output logic                done,
  output logic                error,
  output logic                ARVALID,
  input  logic                ARREADY,
  output logic [ADDR_W-1:0]   ARADDR,
  output logic [7:0]          ARLEN,
  output logic                ARID,
  output logic [2:0]          ARSIZE,
  output logic [1:0]          ARBURST,
  output logic                ARLOCK,
  output logic [3:0]          ARCACHE,
  output logic [2:0]          ARPROT,
  output logic [3:0]          ARQOS,
  output logic                ARUSER,
  input  logic                RVALID,
  output logic                RREADY,
  input  logic [DATA_W-1:0]   RDATA,
  input  logic [1:0]          RRESP,
  input  logic                RLAST,
  output logic                AWVALID,
  input  logic                AWREADY,
  output logic [ADDR_W-1:0]   AWADDR,
  output logic [7:0]          AWLEN,
  output logic                AWID,
  output logic [2:0]          AWSIZE,
  output logic [1:0]          AWBURST,
  output logic                AWLOCK,
  output logic [3:0]          AWCACHE,
  output logic [2:0]          AWPROT,
  output logic [3:0]          AWQOS,
  output logic                AWUSER,
  output logic                WVALID,
  input  logic                WREADY,
  output logic [DATA_W-1:0]   WDATA,
  output logic [DATA_W/8-1:0] WSTRB,
  output logic                WLAST,
  output logic                WUSER,
  input  logic                BVALID,
  output logic                BREADY,
  input  logic [1:0]          BRESP
);
  state_t state, state_nx;
  logic [LEN_W-1:0] len_q, rd_cnt, w_cnt;
  logic [7:0] len_m1;
  logic [ADDR_W-1:0] rd_addr_q, wr_addr_q;
  logic [DATA_W-1:0] add_q, wdata_q, buf_rdata;
  logic [BA_W-1:0] buf_raddr;
  logic wlast_q, error_q, cmd_ok, buf_we, w_hs;
  assign cmd_ok = len != '0 && len <= LEN_W'(MAX_BURST);
  assign buf_we = state == S_R && RVALID && rd_cnt < len_q;
  assign w_hs = state == S_W && WREADY;
  // The W path keeps the buffer read one beat ahead of the beat on the bus; beat 0 is captured straight from R.
  assign buf_raddr = BA_W'(w_cnt + (w_hs ? LEN_W'(2) : LEN_W'(1)));
  assign ARADDR = rd_addr_q;
  assign AWADDR = wr_addr_q;
  assign ARLEN = len_m1;
  assign AWLEN = len_m1;
  assign WDATA = wdata_q;
  assign WLAST = wlast_q;
  assign WSTRB = {(DATA_W/8){WVALID}};
  assign error = error_q;
  assign {ARID, AWID, ARLOCK, AWLOCK} = '0;
  assign {ARPROT, AWPROT, ARQOS, AWQOS} = '0;
  assign {ARUSER, AWUSER, WUSER} = 3'b111;
  assign ARSIZE = axi_size(DATA_W);
  assign AWSIZE = axi_size(DATA_W);
  assign ARBURST = BURST_INCR;
  assign AWBURST = BURST_INCR;
  assign ARCACHE = CACHE_DEFAULT;
  assign AWCACHE = CACHE_DEFAULT;
  rmw_beat_buffer #(.DATA_W(DATA_W), .DEPTH(MAX_BURST)) u_buf (
    .clk(ACLK), .we(buf_we), .waddr(rd_cnt[BA_W-1:0]), .wdata(RDATA),
    .raddr(buf_raddr), .rdata(buf_rdata)
  );
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) state <= S_IDLE;
    else state <= state_nx;
  end
  always_comb begin
    state_nx = state;
    busy = 1'b1;
    done = 1'b0;
    ARVALID = 1'b0;
    RREADY = 1'b0;
    AWVALID = 1'b0;
    WVALID = 1'b0;
    BREADY = 1'b0;
    case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) state_nx = cmd_ok ? S_AR : S_FIN;
      end
      S_AR: begin
        ARVALID = 1'b1;
        if (ARREADY) state_nx = S_R;
      end
      S_R: begin
        RREADY = 1'b1;
        if (RVALID && RLAST) state_nx = S_AW;
      end
      S_AW: begin
        AWVALID = 1'b1;
        if (AWREADY) state_nx = S_W;
      end
      S_W: begin
        WVALID = 1'b1;
        if (WREADY && wlast_q) state_nx = S_B;
      end
      S_B: begin
        BREADY = 1'b1;
        if (BVALID) state_nx = S_FIN;
      end
      S_FIN: begin
        busy = 1'b0;
        done = 1'b1;
        state_nx = S_IDLE;
      end
      default: begin
        busy = 1'b0;
        state_nx = S_IDLE;
      end
    endcase
  end
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      len_q <= '0;
      len_m1 <= '0;
      rd_addr_q <= '0;
      wr_addr_q <= '0;
      add_q <= '0;
      rd_cnt <= '0;
      w_cnt <= '0;
      wdata_q <= '0;
      wlast_q <= 1'b0;
      error_q <= 1'b0;
    end else begin
      if (state == S_IDLE && start) begin
        len_q <= len;
        len_m1 <= 8'(len - LEN_W'(1));
        rd_addr_q <= rd_base_addr;
        wr_addr_q <= wr_base_addr;
        add_q <= add_value;
        rd_cnt <= '0;
        w_cnt <= '0;
        error_q <= !cmd_ok;
      end
      if (state == S_R && RVALID) begin
        if (rd_cnt < len_q) rd_cnt <= rd_cnt + LEN_W'(1);
        if (rd_cnt == '0) wdata_q <= RDATA + add_q;
        // Early RLAST: fewer beats than requested arrived.
        if (RRESP != RESP_OKAY || (RLAST && rd_cnt + LEN_W'(1) < len_q)) error_q <= 1'b1;
      end
      if (state == S_AW && AWREADY) wlast_q <= len_m1 == 8'd0;
      if (w_hs) begin
        wdata_q <= buf_rdata + add_q;
        w_cnt <= w_cnt + LEN_W'(1);
        wlast_q <= w_cnt + LEN_W'(2) == len_q;
      end
      if (state == S_B && BVALID && BRESP != RESP_OKAY) error_q <= 1'b1;
    end
  end
endmodule

// File: doc/axi_burst_rmw_master.md
# axi_burst_rmw_master

Parametrised AXI4 full master performing one read-modify-write burst per command: reads `len` beats from `rd_base_addr`, adds `add_value` to each beat, and writes the results as one burst to `wr_base_addr`. It sits between a PS-side control register block and the PL AXI interconnect/DDR port. It generalises the fixed 32-beat, 64-bit, +1 test master with configurable data width, buffer depth, per-command length and increment, response-error reporting and a busy flag.

## Interface
- `DATA_W`, 64: AXI data width in bits; one of 32, 64, 128.
- `ADDR_W`, 32: AXI address width.
- `MAX_BURST`, 32: beat-buffer depth and maximum `len`; power of two, 2..256.
- `ACLK`  in  1  single clock for all logic.
- `ARESETn`  in  1  asynchronous, active-low reset.
- `start`  in  1  command strobe; sampled only in IDLE.
- `len`  in  clog2(MAX_BURST)+1  beats per command, 1..MAX_BURST; captured at start.
- `rd_base_addr`, `wr_base_addr`  in  ADDR_W  burst start addresses; captured at start.
- `add_value`  in  DATA_W  per-beat increment; captured at start.
- `busy`  out  1  command in progress.
- `done`  out  1  one-cycle completion pulse.
- `error`  out  1  status of the last command; valid with `done`, held until the next start.
- `ARVALID`/`ARREADY`, `ARADDR[ADDR_W]`, `ARLEN[8]`  read-address channel.
- `RVALID`/`RREADY`, `RDATA[DATA_W]`, `RRESP[2]`, `RLAST`  read-data channel.
- `AWVALID`/`AWREADY`, `AWADDR[ADDR_W]`, `AWLEN[8]`  write-address channel.
- `WVALID`/`WREADY`, `WDATA[DATA_W]`, `WSTRB[DATA_W/8]`, `WLAST`  write-data channel.
- `BVALID`/`BREADY`, `BRESP[2]`  write-response channel.
- Constant sideband outputs: ID=0, SIZE=clog2(DATA_W/8), BURST=INCR, LOCK=0, CACHE=4'b0011, PROT=0, QOS=0, USER=1 on AR/AW/W.

## Operation
- FSM states: IDLE, AR, R, AW, W, B, FIN.
- IDLE: on `start`, capture command. If `len`==0 or `len`>MAX_BURST, go to FIN with `error`=1 and issue no bus activity; otherwise go to AR.
- AR: `ARVALID`=1, `ARADDR`=rd base, `ARLEN`=len-1. On handshake, go to R.
- R: `RREADY`=1. Each RVALID&RREADY writes RDATA into buffer[rd_cnt], then rd_cnt++. Any RRESP≠OKAY sets the sticky error flag. On an RLAST beat, go to AW. RLAST before beat len-1 sets error; unread entries keep stale contents. Beats after rd_cnt reaches len are discarded.
- AW: `AWVALID`=1, `AWADDR`=wr base, `AWLEN`=len-1. On handshake, go to W.
- W: beat k carries buffer[k]+add_value, truncated mod 2^DATA_W. `WSTRB` is all ones. `WLAST`=1 exactly on beat len-1. WDATA/WLAST are registered, held stable while WVALID&!WREADY, and advance only on handshake. After the last handshake, go to B.
- B: `BREADY`=1. On BVALID, BRESP≠OKAY sets error; then go to FIN.
- FIN: `done` pulses, return to IDLE.
- `start` outside IDLE is ignored.
- Reset mid-operation: all VALID/READY outputs drop at once and the FSM returns to IDLE. No burst completion is attempted.

## Timing
- Reset values: all VALIDs, READYs, `busy`, `done`, `error`, and WLAST are 0. ADDR/LEN/WDATA/WSTRB are 0.
- `start` at cycle 0 → ARVALID=1 and busy=1 at cycle 1.
- Last R handshake at cycle n → AWVALID=1 at cycle n+1.
- AW handshake at cycle m → first WVALID at cycle m+1. AW and W are not overlapped.
- With WREADY held high, the W phase takes exactly `len` cycles.
- B handshake at cycle p → done=1 and busy=0 at cycle p+1.
- VALIDs never depend combinationally on READYs.
- Error-abort path: start → done in 2 cycles.

## Structure
- Package `axi_rmw_pkg`: state enum; constants RESP_OKAY, BURST_INCR, CACHE_DEFAULT; function computing SIZE from DATA_W.
- Sub-module `rmw_beat_buffer`: MAX_BURST×DATA_W simple dual-port RAM with a synchronous write port and a registered read port, so it can be inferred as BRAM. The W path prefetches one entry ahead to cover read latency.

## Test plan
- DATA_W=64, len=32, add=1, memory holds i at rd addr 0x1000 → 32 writes of i+1 at 0x2000, WLAST on beat 31, done pulse, error=0.
- len=1, add=0xFFFF_FFFF_FFFF_FFFF, data 5 → single beat with WLAST=1 and WDATA=4 (wrap).
- Random RVALID/WREADY/AWREADY back-pressure, len=17 → all data correct, WDATA stable during stalls, no extra beats.
- RRESP=SLVERR on beat 3, then BRESP=OKAY → full write completes, done with error=1.
- len=0 and len=MAX_BURST+1 → no ARVALID, done after 2 cycles, error=1.
- ARESETn asserted during the W phase at beat 10 → all outputs return to reset values at once; a subsequent start runs cleanly.
